// File: rtl/gat_load_pkg.sv
// Shared types and constants for the GAT host load/run controller:
// FSM state encoding, status word bit positions and the channel-count check.
package gat_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } gat_state_e;

  localparam int MAX_CH = 8;

  localparam int STAT_STATE_LSB    = 0;
  localparam int STAT_ERR_MISALIGN = 3;
  localparam int STAT_ERR_OVERFLOW = 4;
  localparam int STAT_ERR_RANGE    = 5;
  localparam int STAT_DONE_LSB     = 8;
  localparam int STAT_RUN_LSB      = 16;

  localparam logic [15:0] RUN_CNT_MAX = 16'hFFFF;

  function automatic bit num_ch_ok(input int n);
    return (n >= 1) && (n <= MAX_CH);
  endfunction

endpackage

// File: rtl/gat_load_ctrl_if.sv
// Host-side write and read bus of the GAT load controller.
// Write: a beat transfers on the cycle where host_wr_valid && host_wr_ready; the
// host holds ch/addr/data stable while valid is high. Read: one request per host_rd_en cycle.
interface gat_load_ctrl_if #(
  parameter int TOP_WIDTH = 32,
  parameter int ADDR_W    = 18,
  parameter int RD_ADDR_W = 16,
  parameter int CH_SEL_W  = 2
) ();

  logic                   host_wr_valid;
  logic                   host_wr_ready;
  logic [CH_SEL_W-1:0]    host_wr_ch;
  logic [ADDR_W+1:0]      host_wr_addr;
  logic [TOP_WIDTH-1:0]   host_wr_data;

  logic                   host_rd_en;
  logic [RD_ADDR_W+1:0]   host_rd_addr;
  logic                   host_rd_valid;
  logic [TOP_WIDTH-1:0]   host_rd_data;

  modport master (
    output host_wr_valid, host_wr_ch, host_wr_addr, host_wr_data,
    output host_rd_en, host_rd_addr,
    input  host_wr_ready, host_rd_valid, host_rd_data
  );

  modport slave (
    input  host_wr_valid, host_wr_ch, host_wr_addr, host_wr_data,
    input  host_rd_en, host_rd_addr,
    output host_wr_ready, host_rd_valid, host_rd_data
  );

endinterface

// File: rtl/gat_load_ch_cnt.sv
// One load channel: latched depth, accepted-word count, done flag and the
// word-address range compare used to reject writes past the programmed depth.
module gat_load_ch_cnt #(
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CNT_W-1:0]  depth_in,
  input  logic              inc,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              in_range,
  output logic              done
);

  logic [CNT_W-1:0] depth_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count_q + CNT_W'(1);
  assign in_range  = CNT_W'(wr_addr) < depth_q;

  // done is compared against the post-edge count so it rises with the completing write
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      count_q <= '0;
      done    <= 1'b0;
    end else if (load) begin
      depth_q <= depth_in;
      count_q <= '0;
      done    <= (depth_in == '0);
    end else if (inc) begin
      count_q <= count_inc;
      done    <= (count_inc == depth_q);
    end
  end

endmodule

// File: rtl/gat_load_ctrl.sv
// Host load/run controller: NUM_CH load channels share one BRAM write port, the
// core is launched once every channel is full, and feature words are read back.
module gat_load_ctrl
  import gat_load_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 18,
  parameter int CNT_W     = 19,
  parameter int RD_ADDR_W = 16,
  parameter int CH_SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_depth,
  gat_load_ctrl_if.slave            host,
  output logic [NUM_CH-1:0]         bram_ena,
  output logic [NUM_CH-1:0]         bram_wea,
  output logic [ADDR_W-1:0]         bram_addra,
  output logic [TOP_WIDTH-1:0]      bram_din,
  output logic [NUM_CH-1:0]         ch_load_done,
  output logic                      gat_start,
  input  logic                      gat_ready,
  output logic [RD_ADDR_W-1:0]      feat_bram_addrb,
  input  logic [TOP_WIDTH-1:0]      feat_bram_dout,
  output logic [31:0]               status
);

  if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
    $error("gat_load_ctrl: NUM_CH must be in 1..8");
  end

  gat_state_e state_q, state_d;

  logic                 cfg_acc;
  logic                 wr_acc;
  logic [ADDR_W-1:0]    wa;
  logic                 misalign;
  logic                 ch_valid;
  logic [NUM_CH-1:0]    ch_hit;
  logic [NUM_CH-1:0]    in_range;
  logic                 sel_done;
  logic                 sel_in_range;
  logic                 commit;
  logic [NUM_CH-1:0]    commit_vec;
  logic                 err_misalign, err_overflow, err_range;
  logic [15:0]          run_cnt;
  logic                 rd_v1;
  logic                 unused_rd_lsb;

  // ---------------- FSM ----------------
  assign cfg_acc = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_start)     state_d = ST_LOAD;
      ST_LOAD:  if (&ch_load_done) state_d = ST_START;
      ST_START:                    state_d = ST_RUN;
      ST_RUN:   if (gat_ready)     state_d = ST_DONE;
      ST_DONE:  if (cfg_start)     state_d = ST_LOAD;
      default:                     state_d = ST_IDLE;
    endcase
  end

  assign gat_start          = (state_q == ST_START);
  assign host.host_wr_ready = (state_q == ST_LOAD);

  // ---------------- write decode ----------------
  assign wr_acc   = host.host_wr_valid && host.host_wr_ready;
  assign wa       = host.host_wr_addr[ADDR_W+1:2];
  assign misalign = |host.host_wr_addr[1:0];
  assign ch_valid = {1'b0, host.host_wr_ch} < (CH_SEL_W+1)'(NUM_CH);

  always_comb begin
    ch_hit = '0;
    for (int c = 0; c < NUM_CH; c++) ch_hit[c] = (host.host_wr_ch == CH_SEL_W'(c));
  end

  assign sel_done     = |(ch_hit & ch_load_done);
  assign sel_in_range = |(ch_hit & in_range);
  // Checks are mutually exclusive: the first failing one claims the beat.
  assign commit       = wr_acc && !misalign && ch_valid && !sel_done && sel_in_range;
  assign commit_vec   = commit ? ch_hit : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_load_ch_cnt #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_ch_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cfg_acc),
      .depth_in (cfg_depth[c*CNT_W +: CNT_W]),
      .inc      (commit_vec[c]),
      .wr_addr  (wa),
      .in_range (in_range[c]),
      .done     (ch_load_done[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bram_ena   <= '0;
      bram_addra <= '0;
      bram_din   <= '0;
    end else begin
      bram_ena <= commit_vec;
      if (commit) begin
        bram_addra <= wa;
        bram_din   <= host.host_wr_data;
      end
    end
  end

  assign bram_wea = bram_ena;

  always_ff @(posedge clk) begin
    if (rst || cfg_acc) begin
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
      err_range    <= 1'b0;
    end else if (wr_acc) begin
      if (misalign)                         err_misalign <= 1'b1;
      else if (!ch_valid || sel_done)       err_overflow <= 1'b1;
      else if (!sel_in_range)               err_range    <= 1'b1;
    end
  end

  // ---------------- run timer ----------------
  always_ff @(posedge clk) begin
    if (rst || cfg_acc)                                 run_cnt <= '0;
    else if (state_q == ST_RUN && run_cnt != RUN_CNT_MAX) run_cnt <= run_cnt + 16'd1;
  end

  // ---------------- read-back pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1              <= 1'b0;
      host.host_rd_valid <= 1'b0;
      feat_bram_addrb    <= '0;
    end else begin
      rd_v1              <= host.host_rd_en;
      host.host_rd_valid <= rd_v1;
      if (host.host_rd_en) feat_bram_addrb <= host.host_rd_addr[RD_ADDR_W+1:2];
    end
  end

  // Feature data is only meaningful once the core has finished.
  assign host.host_rd_data = (state_q == ST_DONE) ? feat_bram_dout : '0;
  assign unused_rd_lsb     = ^host.host_rd_addr[1:0];

  // ---------------- status ----------------
  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: 3]       = state_q;
    status[STAT_ERR_MISALIGN]         = err_misalign;
    status[STAT_ERR_OVERFLOW]         = err_overflow;
    status[STAT_ERR_RANGE]            = err_range;
    status[STAT_DONE_LSB +: NUM_CH]   = ch_load_done;
    status[STAT_RUN_LSB +: 16]        = run_cnt;
  end

endmodule

// File: tb/tb_gat_load_ctrl.sv
// Bench for gat_load_ctrl: directed load/error/run/read scenarios plus randomized
// loads, checked every cycle against a transaction-level model of the controller.
module tb_gat_load_ctrl;

  localparam int TOP_WIDTH = 32;
  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 18;
  localparam int CNT_W     = 19;
  localparam int RD_ADDR_W = 16;
  localparam int CH_SEL_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    cfg_start = 1'b0;
  logic [NUM_CH*CNT_W-1:0] cfg_depth = '0;
  logic [NUM_CH-1:0]       bram_ena, bram_wea, ch_load_done;
  logic [ADDR_W-1:0]       bram_addra;
  logic [TOP_WIDTH-1:0]    bram_din;
  logic                    gat_start;
  logic                    gat_ready = 1'b0;
  logic [RD_ADDR_W-1:0]    feat_bram_addrb;
  logic [TOP_WIDTH-1:0]    feat_bram_dout = '0;
  logic [31:0]             status;

  gat_load_ctrl_if #(
    .TOP_WIDTH(TOP_WIDTH), .ADDR_W(ADDR_W), .RD_ADDR_W(RD_ADDR_W), .CH_SEL_W(CH_SEL_W)
  ) host ();

  gat_load_ctrl #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .RD_ADDR_W(RD_ADDR_W), .CH_SEL_W(CH_SEL_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_depth       (cfg_depth),
    .host            (host),
    .bram_ena        (bram_ena),
    .bram_wea        (bram_wea),
    .bram_addra      (bram_addra),
    .bram_din        (bram_din),
    .ch_load_done    (ch_load_done),
    .gat_start       (gat_start),
    .gat_ready       (gat_ready),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .status          (status)
  );

  // Feature BRAM stand-in: synchronous read of a fixed address pattern.
  function automatic logic [31:0] feat_fn(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  always @(posedge clk) feat_bram_dout <= feat_fn(feat_bram_addrb);

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  bit checking_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbering follows the published state encoding (IDLE..DONE = 0..4).
  int          m_phase = 0;
  int          m_depth[NUM_CH];
  int          m_count[NUM_CH];
  bit          m_loaded = 1'b0;
  bit          m_emis = 1'b0, m_eovf = 1'b0, m_erng = 1'b0;
  int          m_run = 0;
  logic [3:0]  m_ena = '0;
  logic [17:0] m_addra = '0;
  logic [31:0] m_din = '0;
  logic [15:0] m_addrb = '0;
  logic [15:0] m_a1 = '0, m_a2 = '0;
  bit          m_v1 = 1'b0, m_v2 = 1'b0;
  int          cyc_n = 0;
  int          last_wr_cyc = 0;
  int          gs_pulses = 0;
  int          gs_cyc = 0;

  function automatic bit m_done(input int c);
    return m_loaded && (m_count[c] == m_depth[c]);
  endfunction

  function automatic logic [3:0] m_done_vec();
    logic [3:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_done(c);
    return v;
  endfunction

  always @(posedge clk) begin
    int  nphase;
    bit  all_done;
    int  ch;
    int  wa;
    cyc_n++;
    m_ena = '0;
    if (rst) begin
      m_phase = 0; m_loaded = 1'b0;
      m_emis = 1'b0; m_eovf = 1'b0; m_erng = 1'b0; m_run = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_depth[c] = 0; m_count[c] = 0; end
      m_addra = '0; m_din = '0; m_addrb = '0;
      m_v1 = 1'b0; m_v2 = 1'b0;
    end else begin
      all_done = (m_done_vec() == 4'hF);
      nphase   = m_phase;
      m_v2 = m_v1; m_a2 = m_a1;
      m_v1 = host.host_rd_en;
      if (host.host_rd_en) begin
        m_a1    = host.host_rd_addr[17:2];
        m_addrb = host.host_rd_addr[17:2];
      end
      case (m_phase)
        0, 4: if (cfg_start) begin
          nphase = 1; m_loaded = 1'b1;
          m_emis = 1'b0; m_eovf = 1'b0; m_erng = 1'b0; m_run = 0;
          for (int c = 0; c < NUM_CH; c++) begin
            m_depth[c] = int'(cfg_depth[c*CNT_W +: CNT_W]);
            m_count[c] = 0;
          end
        end
        1: begin
          if (host.host_wr_valid) begin
            ch = int'(host.host_wr_ch);
            wa = int'(host.host_wr_addr[19:2]);
            if (host.host_wr_addr[1:0] != 2'b00)      m_emis = 1'b1;
            else if (ch >= NUM_CH || m_done(ch))      m_eovf = 1'b1;
            else if (wa >= m_depth[ch])               m_erng = 1'b1;
            else begin
              m_ena[ch] = 1'b1; m_addra = 18'(wa); m_din = host.host_wr_data;
              m_count[ch]++; last_wr_cyc = cyc_n - 1;
            end
          end
          if (all_done) nphase = 2;
        end
        2: nphase = 3;
        3: begin
          if (m_run < 65535) m_run++;
          if (gat_ready) nphase = 4;
        end
        default: nphase = 0;
      endcase
      m_phase = nphase;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [31:0] exp_status;
    if (checking_on) begin
      exp_status = {16'(m_run), 4'b0, m_done_vec(), 2'b00, m_erng, m_eovf, m_emis, 3'(m_phase)};
      check("wr_ready",  host.host_wr_ready, m_phase == 1);
      check("bram_ena",  bram_ena, m_ena);
      check("bram_wea",  bram_wea, m_ena);
      check("bram_addra", bram_addra, m_addra);
      check("bram_din",  bram_din, m_din);
      check("load_done", ch_load_done, m_done_vec());
      check("gat_start", gat_start, m_phase == 2);
      check("status",    status, exp_status);
      check("addrb",     feat_bram_addrb, m_addrb);
      check("rd_valid",  host.host_rd_valid, m_v2);
      if (m_v2) check("rd_data", host.host_rd_data, (m_phase == 4) ? feat_fn(m_a2) : 32'h0);
      if (gat_start) begin gs_pulses++; gs_cyc = cyc_n; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [19:0] addr);
    host.host_wr_valid = 1'b1;
    host.host_wr_ch    = ch;
    host.host_wr_addr  = addr;
    host.host_wr_data  = $urandom;
    cyc();
    host.host_wr_valid = 1'b0;
  endtask

  task automatic start_load(input logic [NUM_CH*CNT_W-1:0] d);
    cfg_depth = d; cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n = 0;
    while (status[2:0] != st && n < budget) begin cyc(); n++; end
    check("wait_state", status[2:0], st);
  endtask

  task automatic rand_read();
    host.host_rd_en   = ($urandom_range(0, 9) < 4);
    host.host_rd_addr = 18'($urandom_range(0, 255));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int n;
    host.host_wr_valid = 1'b0; host.host_wr_ch = '0; host.host_wr_addr = '0;
    host.host_wr_data = '0; host.host_rd_en = 1'b0; host.host_rd_addr = '0;
    cyc();
    checking_on = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_status", status, 32'h0);
    check("rst_done", ch_load_done, 4'h0);
    check("rst_ready", host.host_wr_ready, 1'b0);
    cyc();

    // Load A: depths {3,2,1,0} with an overflow and a misaligned write mixed in.
    start_load({19'd0, 19'd1, 19'd2, 19'd3});
    gs_pulses = 0;
    wr(2'd0, 20'h0); wr(2'd0, 20'h4); wr(2'd0, 20'h8);
    wr(2'd0, 20'hC);
    wr(2'd1, 20'h6);
    check("err_bits_a", status[5:3], 3'b011);
    wr(2'd1, 20'h0); wr(2'd1, 20'h4); wr(2'd2, 20'h0);
    check("done_all", ch_load_done, 4'hF);
    wait_state(3'd3, 20);
    check("gs_pulses", gs_pulses, 1);
    check("gs_delay", 32'(gs_cyc - last_wr_cyc), 32'd2);
    repeat (10) cyc();
    gat_ready = 1'b1; cyc(); gat_ready = 1'b0;
    check("done_state", status[2:0], 3'd4);
    check("run_cnt_11", status[31:16], 16'd11);

    // Read-back in DONE, then a back-to-back burst.
    host.host_rd_en = 1'b1; host.host_rd_addr = 18'h8; cyc();
    host.host_rd_en = 1'b0;
    check("addrb_2", feat_bram_addrb, 16'd2);
    cyc();
    check("rd_valid_lit", host.host_rd_valid, 1'b1);
    check("rd_data_lit", host.host_rd_data, 32'h5A580002);
    for (int i = 0; i < 6; i++) begin
      host.host_rd_en = 1'b1; host.host_rd_addr = 18'($urandom_range(0, 1023)); cyc();
    end
    host.host_rd_en = 1'b0;
    cyc(); cyc();

    // Load B: range error, read during LOAD, then reset mid-load.
    start_load({19'd4, 19'd2, 19'd0, 19'd1});
    wr(2'd3, 20'h14);
    check("err_bits_b", status[5:3], 3'b100);
    host.host_rd_en = 1'b1; host.host_rd_addr = 18'h10; cyc();
    host.host_rd_en = 1'b0; cyc();
    check("rd_load_valid", host.host_rd_valid, 1'b1);
    check("rd_load_data", host.host_rd_data, 32'h0);
    wr(2'd2, 20'h0); wr(2'd2, 20'h4);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rst_mid_status", status, 32'h0);
    check("rst_mid_done", ch_load_done, 4'h0);
    cyc();

    // Randomized loads, each run with a cfg_start issued (and ignored) in RUN.
    for (int it = 0; it < 8; it++) begin
      start_load({19'($urandom_range(0, 5)), 19'($urandom_range(0, 5)),
                  19'($urandom_range(0, 5)), 19'($urandom_range(0, 5))});
      n = 0;
      while (status[2:0] == 3'd1 && n < 400) begin
        host.host_wr_valid = ($urandom_range(0, 9) < 8);
        host.host_wr_ch    = 2'($urandom_range(0, 3));
        host.host_wr_addr  = 20'($urandom_range(0, 6) * 4) |
                             20'(($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
        host.host_wr_data  = $urandom;
        rand_read();
        cyc(); n++;
      end
      host.host_wr_valid = 1'b0; host.host_rd_en = 1'b0;
      wait_state(3'd3, 10);
      r = (it == 0) ? 0 : $urandom_range(1, 8);
      gat_ready = (r == 0); cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      if (r > 0) begin
        repeat (r - 1) cyc();
        gat_ready = 1'b1; cyc();
      end
      gat_ready = 1'b0;
      wait_state(3'd4, 10);
      if (it == 0) check("run_cnt_1", status[31:16], 16'd1);
      for (int k = 0; k < 6; k++) begin rand_read(); cyc(); end
      host.host_rd_en = 1'b0;
      cyc(); cyc();
    end

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
